// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//   Time-multiplexed 8-digit hex driver for the board 7-segment display.
//   Captures a 32-bit result word (plus 8 decimal points) on the rising edge
//   of disp_load and scans it one nibble per digit onto the shared pins.
//   Supports leading-zero blanking and a freeze control for single-step debug.
//
// Parameters
//   SCAN_DIV     clk cycles per digit slot (>=1)
//
// Ports
//   clk          board clock, all logic on posedge
//   rstn         asynchronous reset, active-low
//   disp_data    value to show; nibble k -> digit k (digit 0 rightmost)
//   disp_dp      decimal point per digit, 1 = lit; captured with disp_data
//   disp_load    capture strobe; acts on its rising edge
//   disp_freeze  1 = ignore load edges, hold the current shadow value
//   disp_blank   1 = leading-zero blanking enabled (live, not captured)
//   disp_an_o    digit anodes, active-low, one-hot-low while scanning
//   disp_seg_o   segments, active-low; [7]=dp, [6:0]=g,f,e,d,c,b,a
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] disp_data,
  input  logic [7:0]  disp_dp,
  input  logic        disp_load,
  input  logic        disp_freeze,
  input  logic        disp_blank,
  output logic [7:0]  disp_an_o,
  output logic [7:0]  disp_seg_o
);

  localparam int            CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;
  logic [2:0]    idx;
  logic          load_q;
  logic          load_edge;
  logic [31:0]   shadow;
  logic [7:0]    shadow_dp;

  logic [2:0]    msd;
  logic [3:0]    nib;
  logic          blank_digit;
  logic [7:0]    seg_next;

  // Hex digit to active-low g..a pattern (dp handled separately).
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  assign tick      = (cnt == CNT_MAX);
  assign load_edge = disp_load & ~load_q;

  // Prescaler and digit index. The index only ever moves on tick, so a
  // mid-scan load never disturbs the scan sequence.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= idx + 3'd1;
    end
  end

  // Load-edge capture. An edge while frozen is simply dropped; a held-high
  // load produces only one edge and therefore one capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load_q    <= 1'b0;
      shadow    <= '0;
      shadow_dp <= '0;
    end else begin
      load_q <= disp_load;
      if (load_edge && !disp_freeze) begin
        shadow    <= disp_data;
        shadow_dp <= disp_dp;
      end
    end
  end

  // Most significant nonzero nibble; stays 0 for an all-zero word so digit 0
  // is never blanked.
  // NOTE: every combinational output gets a default before any conditional
  // update, which keeps the block free of inferred latches.
  always_comb begin
    msd = '0;
    for (int k = 1; k < 8; k++) begin
      if (shadow[4*k +: 4] != 4'h0) msd = 3'(k);
    end
  end

  assign nib         = shadow[{idx, 2'b00} +: 4];
  assign blank_digit = disp_blank && (idx > msd);
  assign seg_next    = {~shadow_dp[idx], blank_digit ? 7'h7F : hex_seg(nib)};

  // Registered output stage: one cycle behind idx/shadow, and no input can
  // reach the pins combinationally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disp_an_o  <= 8'hFF;
      disp_seg_o <= 8'hFF;
    end else begin
      disp_an_o  <= ~(8'b1 << idx);
      disp_seg_o <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] disp_data;
  logic [7:0]  disp_dp;
  logic        disp_load, disp_freeze, disp_blank;
  logic [7:0]  disp_an_o, disp_seg_o;

  logic        rstn1;
  logic [31:0] data1;
  logic        load1;
  logic [7:0]  an1, seg1;

  int errors = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rstn(rstn), .disp_data(disp_data), .disp_dp(disp_dp),
    .disp_load(disp_load), .disp_freeze(disp_freeze), .disp_blank(disp_blank),
    .disp_an_o(disp_an_o), .disp_seg_o(disp_seg_o)
  );

  seg7_scan_ctrl #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .rstn(rstn1), .disp_data(data1), .disp_dp(8'h00),
    .disp_load(load1), .disp_freeze(1'b0), .disp_blank(1'b0),
    .disp_an_o(an1), .disp_seg_o(seg1)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dp;
    logic        blank;
    logic [63:0] exp_seg;  // byte k = expected seg for digit slot k
  } vec_t;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[7];

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_pulse(input logic [31:0] d, input logic [7:0] p);
    @(negedge clk);
    disp_data = d;
    disp_dp   = p;
    disp_load = 1'b1;
    @(negedge clk);
    disp_load = 1'b0;
  endtask

  task automatic push_scan(input logic [63:0] segs);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.an  = ~(8'b1 << k);
      e.seg = segs[8*k +: 8];
      exp_q.push_back(e);
    end
  endtask

  // Align to the first cycle of slot 0, then compare one entry per slot.
  task automatic drain_scan(input string tag);
    exp_t e;
    int   t;
    t = 0;
    while (disp_an_o !== 8'h7F && t < 80) begin @(negedge clk); t++; end
    while (disp_an_o !== 8'hFE && t < 90) begin @(negedge clk); t++; end
    if (t >= 90) begin
      n_checks++;
      errors++;
      $display("FAIL %s_align: timeout, an=%h expected scan reaching FE", tag, disp_an_o);
      exp_q.delete();
      return;
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_an%0d", tag, k), disp_an_o, e.an);
      check($sformatf("%s_seg%0d", tag, k), disp_seg_o, e.seg);
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] sh;
    int          ie;

    vecs[0] = '{32'h1234ABCD, 8'h00, 1'b0, 64'hF9A4B0998883C6A1};
    vecs[1] = '{32'h000000F0, 8'h00, 1'b1, 64'hFFFFFFFFFFFF8EC0};
    vecs[2] = '{32'h00000000, 8'h00, 1'b1, 64'hFFFFFFFFFFFFFFC0};
    vecs[3] = '{32'h00000000, 8'h00, 1'b0, 64'hC0C0C0C0C0C0C0C0};
    vecs[4] = '{32'h00000000, 8'h04, 1'b1, 64'hFFFFFFFFFF7FFFC0};
    vecs[5] = '{32'h00000000, 8'h04, 1'b0, 64'hC0C0C0C0C040C0C0};
    vecs[6] = '{32'h00F00005, 8'h81, 1'b1, 64'h7FFF8EC0C0C0C012};

    rstn = 1'b0; rstn1 = 1'b0;
    disp_data = '0; disp_dp = '0; disp_load = 1'b0;
    disp_freeze = 1'b0; disp_blank = 1'b0;
    data1 = '0; load1 = 1'b0;

    // Reset state and scan order after release
    repeat (2) @(negedge clk);
    check("rst_an", disp_an_o, 8'hFF);
    check("rst_seg", disp_seg_o, 8'hFF);
    rstn = 1'b1;
    @(negedge clk);
    check("rel_an", disp_an_o, 8'hFE);
    check("rel_seg", disp_seg_o, 8'hC0);
    for (int k = 1; k <= 8; k++) begin
      repeat (4) @(negedge clk);
      check($sformatf("rot_an%0d", k), disp_an_o, ~(8'b1 << (k % 8)));
    end

    // Table-driven patterns through the scoreboard
    for (int v = 0; v < 7; v++) begin
      disp_blank = vecs[v].blank;
      load_pulse(vecs[v].data, vecs[v].dp);
      push_scan(vecs[v].exp_seg);
      drain_scan($sformatf("vec%0d", v));
    end

    // Held-high load captures only once
    disp_blank = 1'b0;
    @(negedge clk);
    disp_data = 32'h00000042; disp_dp = 8'h00; disp_load = 1'b1;
    repeat (2) @(negedge clk);
    disp_data = 32'h00000077;
    repeat (8) @(negedge clk);
    disp_load = 1'b0;
    push_scan(64'hC0C0C0C0C0C099A4);
    drain_scan("hold");

    // Edge while frozen is discarded
    disp_freeze = 1'b1;
    load_pulse(32'hFFFFFFFF, 8'hFF);
    push_scan(64'hC0C0C0C0C0C099A4);
    drain_scan("frz");

    // Unfreezing does not replay the discarded edge
    disp_freeze = 1'b0;
    push_scan(64'hC0C0C0C0C0C099A4);
    drain_scan("unfrz");

    // Asynchronous reset mid-scan clears outputs and shadow
    repeat (6) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_an", disp_an_o, 8'hFF);
    check("mid_rst_seg", disp_seg_o, 8'hFF);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("mid_rel_an", disp_an_o, 8'hFE);
    check("mid_rel_seg", disp_seg_o, 8'hC0);

    // SCAN_DIV=1: rotation every cycle, load coinciding with a tick
    @(negedge clk);
    rstn1 = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      ie = (n - 1) % 8;
      sh = (n >= 6) ? 32'h76543210 : 32'h0;
      check($sformatf("d1_an%0d", n), an1, ~(8'b1 << ie));
      check($sformatf("d1_seg%0d", n), seg1, hex_tab[(sh >> (4 * ie)) & 32'hF]);
      if (n == 4) begin data1 = 32'h76543210; load1 = 1'b1; end
      if (n == 5) load1 = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
